// File: rtl/rfile_sweep_pkg.sv
// Shared definitions for the rfile_sweep register file.
//   - sweepState_t : state of the sweep-clear FSM (IDLE, CLEAR)
//   - DW_DEF, AW_DEF, SCAN_DIV_DEF : default data width, index width, scan divider
//   - nibblePair_t / splitNibbles : low/high nibble split of a write byte
package rfile_sweep_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } sweepState_t;

    localparam int DW_DEF       = 8;
    localparam int AW_DEF       = 2;
    localparam int SCAN_DIV_DEF = 4;

    typedef struct packed {
        logic [3:0] hi;
        logic [3:0] lo;
    } nibblePair_t;

    function automatic nibblePair_t splitNibbles(input logic [7:0] byteIn);
        nibblePair_t pair;
        pair.hi = byteIn[7:4];
        pair.lo = byteIn[3:0];
        return pair;
    endfunction

endpackage

// File: rtl/rfile_sweep_if.sv
// Register-file access bus: two read ports, one write port and the
// sweep-clear handshake.
//   rd_idx1/rd_data1, rd_idx2/rd_data2 : combinational read ports
//   wr_idx/wr_data/wr_en               : write port
//   clr_req/busy                       : sweep-clear request and busy flag
// master = the datapath driving the file, slave = the register file itself.
interface rfile_sweep_if
    import rfile_sweep_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
);
    logic [AW-1:0] rd_idx1;
    logic [DW-1:0] rd_data1;
    logic [AW-1:0] rd_idx2;
    logic [DW-1:0] rd_data2;
    logic [AW-1:0] wr_idx;
    logic [DW-1:0] wr_data;
    logic          wr_en;
    logic          clr_req;
    logic          busy;

    modport master (
        output rd_idx1, rd_idx2, wr_idx, wr_data, wr_en, clr_req,
        input  rd_data1, rd_data2, busy
    );

    modport slave (
        input  rd_idx1, rd_idx2, wr_idx, wr_data, wr_en, clr_req,
        output rd_data1, rd_data2, busy
    );
endinterface

// File: rtl/rfile_sweep_scanner.sv
// Display scanner: steps through every register once per SCAN_DIV clocks and
// presents a registered (index, data) pair for the seven-segment driver.
//   clk, clr              : clock, asynchronous active-low reset
//   rdIdx / rdData        : read access into the register storage
//   scan_idx / scan_data  : register shown on the display and its contents
//   scan_valid            : one-cycle pulse when scan_idx/scan_data update
module rfile_scanner
    import rfile_sweep_pkg::*;
#(
    parameter int DW       = DW_DEF,
    parameter int AW       = AW_DEF,
    parameter int SCAN_DIV = SCAN_DIV_DEF
) (
    input  logic          clk,
    input  logic          clr,
    output logic [AW-1:0] rdIdx,
    input  logic [DW-1:0] rdData,
    output logic [AW-1:0] scan_idx,
    output logic [DW-1:0] scan_data,
    output logic          scan_valid
);
    // With SCAN_DIV=1 the prescaler degenerates to a single bit held at 0,
    // so every cycle is a step cycle.
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

    logic [PW-1:0] presc;
    logic [AW-1:0] sptr;
    logic          stepNow;

    assign stepNow = (presc == PRESC_LAST);
    assign rdIdx   = sptr;

    // rdData is the pre-edge storage value, so a write landing on the same
    // edge is not captured. sptr wraps naturally because DEPTH = 2**AW.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            presc      <= '0;
            sptr       <= '0;
            scan_idx   <= '0;
            scan_data  <= '0;
            scan_valid <= 1'b0;
        end else begin
            presc      <= stepNow ? '0 : presc + PW'(1);
            scan_valid <= stepNow;
            if (stepNow) begin
                scan_idx  <= sptr;
                scan_data <= rdData;
                sptr      <= sptr + AW'(1);
            end
        end
    end
endmodule

// File: rtl/rfile_sweep.sv
// Parametrised register file with two combinational read ports, one write
// port, optional write-to-read bypass, optional hardwired-zero R0, a
// multi-cycle sweep-clear FSM and a display scanner.
//   clk, clr                       : clock, asynchronous active-low reset
//   bus (rfile_sweep_if.slave)     : read/write ports and clr_req/busy
//   scan_idx, scan_data, scan_valid: display scanner outputs
//   num1, num2                     : low/high nibble of the last accepted write
module rfile_sweep
    import rfile_sweep_pkg::*;
#(
    parameter int DW       = DW_DEF,
    parameter int AW       = AW_DEF,
    parameter int ZERO_R0  = 0,
    parameter int BYPASS   = 1,
    parameter int SCAN_DIV = SCAN_DIV_DEF
) (
    input  logic          clk,
    input  logic          clr,
    rfile_sweep_if.slave  bus,
    output logic [AW-1:0] scan_idx,
    output logic [DW-1:0] scan_data,
    output logic          scan_valid,
    output logic [3:0]    num1,
    output logic [3:0]    num2
);
    localparam int DEPTH = 2 ** AW;

    logic [DW-1:0] regs [DEPTH];
    sweepState_t   state, nextState;
    logic [AW-1:0] sweepPtr, nextPtr;
    logic          accept;
    logic          writeToZero;
    logic [DW-1:0] rdData1, rdData2;
    logic [AW-1:0] scanRdIdx;
    logic [DW-1:0] scanRdData;
    nibblePair_t   wrNibbles;

    // Writes are only honoured outside a sweep; this also gates bypass and
    // the nibble registers.
    assign accept      = bus.wr_en && (state == IDLE);
    assign writeToZero = (ZERO_R0 != 0) && (bus.wr_idx == '0);
    assign wrNibbles   = splitNibbles(bus.wr_data[7:0]);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state    <= IDLE;
            sweepPtr <= '0;
        end else begin
            state    <= nextState;
            sweepPtr <= nextPtr;
        end
    end

    // clr_req is only looked at in IDLE. The sweep ends after the cycle in
    // which the pointer is all ones (index DEPTH-1).
    always_comb begin
        nextState = state;
        nextPtr   = sweepPtr;
        bus.busy  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.clr_req) begin
                    nextState = CLEAR;
                    nextPtr   = '0;
                end
            end
            CLEAR: begin
                bus.busy = 1'b1;
                if (&sweepPtr) begin
                    nextState = IDLE;
                    nextPtr   = '0;
                end else begin
                    nextPtr = sweepPtr + AW'(1);
                end
            end
            default: begin
                nextState = IDLE;
                nextPtr   = '0;
            end
        endcase
    end

    // A write accepted on the clr_req cycle lands before the sweep starts,
    // so the sweep clears it later.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (state == CLEAR) begin
            regs[sweepPtr] <= '0;
        end else if (accept && !writeToZero) begin
            regs[bus.wr_idx] <= bus.wr_data;
        end
    end

    // A write to index 0 with ZERO_R0 still counts as accepted here.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            num1 <= '0;
            num2 <= '0;
        end else if (accept) begin
            num1 <= wrNibbles.lo;
            num2 <= wrNibbles.hi;
        end
    end

    // Zero forcing is applied last so it overrides bypass on index 0.
    always_comb begin
        rdData1 = regs[bus.rd_idx1];
        if ((BYPASS != 0) && accept && (bus.wr_idx == bus.rd_idx1)) begin
            rdData1 = bus.wr_data;
        end
        if ((ZERO_R0 != 0) && (bus.rd_idx1 == '0)) begin
            rdData1 = '0;
        end
    end

    always_comb begin
        rdData2 = regs[bus.rd_idx2];
        if ((BYPASS != 0) && accept && (bus.wr_idx == bus.rd_idx2)) begin
            rdData2 = bus.wr_data;
        end
        if ((ZERO_R0 != 0) && (bus.rd_idx2 == '0)) begin
            rdData2 = '0;
        end
    end

    assign bus.rd_data1 = rdData1;
    assign bus.rd_data2 = rdData2;
    assign scanRdData   = regs[scanRdIdx];

    rfile_scanner #(
        .DW       (DW),
        .AW       (AW),
        .SCAN_DIV (SCAN_DIV)
    ) scanner (
        .clk        (clk),
        .clr        (clr),
        .rdIdx      (scanRdIdx),
        .rdData     (scanRdData),
        .scan_idx   (scan_idx),
        .scan_data  (scan_data),
        .scan_valid (scan_valid)
    );
endmodule

// File: tb/tb_rfile_sweep.sv
// Directed testbench for rfile_sweep. Two instances share one stimulus:
//   dut  : BYPASS=1, ZERO_R0=0, SCAN_DIV=4
//   dutB : BYPASS=0, ZERO_R0=1, SCAN_DIV=1
module tb_rfile_sweep;
    import rfile_sweep_pkg::*;

    localparam int DW    = DW_DEF;
    localparam int AW    = AW_DEF;
    localparam int DEPTH = 2 ** AW;

    logic clk = 1'b0;
    logic clr = 1'b0;

    rfile_sweep_if #(.DW(DW), .AW(AW)) bus ();
    rfile_sweep_if #(.DW(DW), .AW(AW)) busB ();

    logic [AW-1:0] scanIdx, scanIdxB;
    logic [DW-1:0] scanData, scanDataB;
    logic          scanValid, scanValidB;
    logic [3:0]    num1, num2, num1B, num2B;

    int checkCount;
    int errorCount;
    int busyCycles;
    int guard;

    logic [7:0] loadVals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0] scanVals [4] = '{8'h10, 8'h20, 8'h30, 8'h40};

    always #5 clk = ~clk;

    assign busB.rd_idx1 = bus.rd_idx1;
    assign busB.rd_idx2 = bus.rd_idx2;
    assign busB.wr_idx  = bus.wr_idx;
    assign busB.wr_data = bus.wr_data;
    assign busB.wr_en   = bus.wr_en;
    assign busB.clr_req = bus.clr_req;

    rfile_sweep #(
        .DW(DW), .AW(AW), .ZERO_R0(0), .BYPASS(1), .SCAN_DIV(4)
    ) dut (
        .clk(clk), .clr(clr), .bus(bus),
        .scan_idx(scanIdx), .scan_data(scanData), .scan_valid(scanValid),
        .num1(num1), .num2(num2)
    );

    rfile_sweep #(
        .DW(DW), .AW(AW), .ZERO_R0(1), .BYPASS(0), .SCAN_DIV(1)
    ) dutB (
        .clk(clk), .clr(clr), .bus(busB),
        .scan_idx(scanIdxB), .scan_data(scanDataB), .scan_valid(scanValidB),
        .num1(num1B), .num2(num2B)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic wrEn, input int wrIdx, input logic [7:0] wrData,
                                 input logic clrReq, input int rdIdx1, input int rdIdx2);
        bus.wr_en   = wrEn;
        bus.wr_idx  = AW'(wrIdx);
        bus.wr_data = wrData;
        bus.clr_req = clrReq;
        bus.rd_idx1 = AW'(rdIdx1);
        bus.rd_idx2 = AW'(rdIdx2);
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic readCheck(input string tag, input int idx, input logic [7:0] expected);
        bus.rd_idx1 = AW'(idx);
        #1;
        checkOutput(tag, bus.rd_data1, expected);
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        applyStimulus(1'b0, 0, 8'h00, 1'b0, 0, 0);
        repeat (2) step();

        // Reset state
        checkOutput("reset busy", bus.busy, 0);
        checkOutput("reset num1", num1, 0);
        checkOutput("reset num2", num2, 0);
        checkOutput("reset scanValid", scanValid, 0);
        checkOutput("reset scanIdx", scanIdx, 0);
        checkOutput("reset scanData", scanData, 0);
        for (int i = 0; i < DEPTH; i++) readCheck($sformatf("reset R%0d", i), i, 8'h00);
        clr = 1'b1;
        step();

        // Test 1: basic write and nibbles
        applyStimulus(1'b1, 2, 8'hA5, 1'b0, 2, 0);
        step();
        applyStimulus(1'b0, 0, 8'h00, 1'b0, 2, 0);
        checkOutput("t1 R2", bus.rd_data1, 8'hA5);
        checkOutput("t1 num1", num1, 4'h5);
        checkOutput("t1 num2", num2, 4'hA);
        checkOutput("t1 num1B", num1B, 4'h5);
        checkOutput("t1 num2B", num2B, 4'hA);
        readCheck("t1 R0", 0, 8'h00);
        readCheck("t1 R1", 1, 8'h00);
        readCheck("t1 R3", 3, 8'h00);

        // Test 2: bypass vs no bypass
        applyStimulus(1'b1, 1, 8'h3C, 1'b0, 2, 1);
        checkOutput("t2 bypass rd2", bus.rd_data2, 8'h3C);
        checkOutput("t2 nobypass rd2", busB.rd_data2, 8'h00);
        checkOutput("t2 other idx rd1", bus.rd_data1, 8'hA5);
        step();
        applyStimulus(1'b0, 0, 8'h00, 1'b0, 2, 1);
        checkOutput("t2 nobypass after edge", busB.rd_data2, 8'h3C);

        // Test 4: hardwired zero R0 on dutB
        applyStimulus(1'b1, 0, 8'hFF, 1'b0, 0, 0);
        checkOutput("t4 bypass R0 dut", bus.rd_data1, 8'hFF);
        checkOutput("t4 zero R0 before edge", busB.rd_data1, 8'h00);
        step();
        applyStimulus(1'b0, 0, 8'h00, 1'b0, 0, 0);
        checkOutput("t4 zero R0 dutB", busB.rd_data1, 8'h00);
        checkOutput("t4 num1B", num1B, 4'hF);
        checkOutput("t4 num2B", num2B, 4'hF);
        checkOutput("t4 R0 dut", bus.rd_data1, 8'hFF);

        // Test 3: sweep clear with concurrent write
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, i, loadVals[i], 1'b0, 0, 0);
            step();
        end
        applyStimulus(1'b1, 3, 8'h77, 1'b1, 3, 0);
        step();
        applyStimulus(1'b1, 1, 8'h99, 1'b0, 3, 1);
        checkOutput("t3 busy first", bus.busy, 1);
        checkOutput("t3 R3 written first", bus.rd_data1, 8'h77);
        checkOutput("t3 no bypass while busy", bus.rd_data2, 8'h22);
        busyCycles = 0;
        guard = 0;
        while (bus.busy && guard < 20) begin
            busyCycles++;
            if (busyCycles == 2) begin
                applyStimulus(1'b1, 1, 8'h99, 1'b0, 0, 3);
                checkOutput("t3 R0 cleared", bus.rd_data1, 8'h00);
                checkOutput("t3 R3 still set", bus.rd_data2, 8'h77);
            end
            step();
            guard++;
        end
        applyStimulus(1'b0, 0, 8'h00, 1'b0, 0, 0);
        checkOutput("t3 busy cycles", busyCycles, 4);
        checkOutput("t3 busyB low", busB.busy, 0);
        checkOutput("t3 num1 held", num1, 4'h7);
        checkOutput("t3 num2 held", num2, 4'h7);
        for (int i = 0; i < DEPTH; i++) readCheck($sformatf("t3 R%0d zero", i), i, 8'h00);

        // Test 5: scanner sequence
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, i, scanVals[i], 1'b0, 0, 0);
            step();
        end
        applyStimulus(1'b0, 0, 8'h00, 1'b0, 0, 0);
        checkOutput("t5 scanValidB steady", scanValidB, 1);
        guard = 0;
        while (!(scanValid && scanIdx == '0) && guard < 40) begin
            step();
            guard++;
        end
        checkOutput("t5 scan sync", (guard < 40) ? 1 : 0, 1);
        for (int k = 0; k <= DEPTH; k++) begin
            if (k > 0) begin
                for (int j = 0; j < 3; j++) begin
                    step();
                    checkOutput($sformatf("t5 gap %0d.%0d", k, j), scanValid, 0);
                end
                step();
            end
            checkOutput($sformatf("t5 pulse %0d", k), scanValid, 1);
            checkOutput($sformatf("t5 idx %0d", k), scanIdx, k % DEPTH);
            checkOutput($sformatf("t5 data %0d", k), scanData, scanVals[k % DEPTH]);
        end

        // Test 6: reset in the middle of a sweep
        applyStimulus(1'b0, 0, 8'h00, 1'b1, 2, 0);
        step();
        applyStimulus(1'b0, 0, 8'h00, 1'b0, 2, 0);
        step();
        step();
        checkOutput("t6 busy mid", bus.busy, 1);
        checkOutput("t6 R2 not yet cleared", bus.rd_data1, 8'h30);
        #2;
        clr = 1'b0;
        #1;
        checkOutput("t6 busy async", bus.busy, 0);
        checkOutput("t6 busyB async", busB.busy, 0);
        checkOutput("t6 num2 async", num2, 0);
        checkOutput("t6 scanValid async", scanValid, 0);
        checkOutput("t6 scanIdx async", scanIdx, 0);
        checkOutput("t6 scanData async", scanData, 0);
        for (int i = 0; i < DEPTH; i++) readCheck($sformatf("t6 R%0d async", i), i, 8'h00);
        step();
        clr = 1'b1;
        step();
        applyStimulus(1'b1, 3, 8'h55, 1'b1, 3, 0);
        step();
        applyStimulus(1'b0, 0, 8'h00, 1'b0, 3, 0);
        checkOutput("t6 R3 before resweep", bus.rd_data1, 8'h55);
        busyCycles = 0;
        guard = 0;
        while (bus.busy && guard < 20) begin
            busyCycles++;
            step();
            guard++;
        end
        checkOutput("t6 full sweep cycles", busyCycles, 4);
        readCheck("t6 R3 cleared", 3, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end
endmodule
